// File: rtl/trg_dec_pkg.sv
// Shared constants for the trigger-line decoder: FSM encoding, width classes, check period.
package trg_dec_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MEAS_TRG = 3'd1;
  localparam logic [2:0] ST_WAIT_CHK = 3'd2;
  localparam logic [2:0] ST_MEAS_CHK = 3'd3;
  localparam logic [2:0] ST_STUCK    = 3'd4;

  localparam logic [1:0] WC_GLITCH = 2'd0;
  localparam logic [1:0] WC_TRG    = 2'd1;
  localparam logic [1:0] WC_CHK    = 2'd2;
  localparam logic [1:0] WC_BAD    = 2'd3;

  localparam int CHK_PERIOD_BITS = 12;

  function automatic logic [1:0] width_class(
    input logic [7:0] w,
    input logic [7:0] trg_min,
    input logic [7:0] trg_max,
    input logic [7:0] chk_min,
    input logic [7:0] chk_max
  );
    logic [1:0] c;
    if (w < trg_min)                    c = WC_GLITCH;
    else if (w <= trg_max)              c = WC_TRG;
    else if (w >= chk_min && w <= chk_max) c = WC_CHK;
    else                                c = WC_BAD;
    return c;
  endfunction

endpackage

// File: rtl/trg_line_sync.sv
// 2-FF synchroniser plus registered edge detect; line_lvl, line_fall and line_rise are cycle-aligned.
// Latency 3 clocks from the pin; no backpressure. Resets to the low level so a line held low is not seen as a new edge.
module trg_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic line_in,
  output logic line_lvl,
  output logic line_fall,
  output logic line_rise
);

  logic sync1, sync2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      line_lvl  <= 1'b0;
      line_fall <= 1'b0;
      line_rise <= 1'b0;
    end else begin
      sync1     <= line_in;
      sync2     <= sync1;
      line_lvl  <= sync2;
      line_fall <= line_lvl & ~sync2;
      line_rise <= ~line_lvl & sync2;
    end
  end

endmodule

// File: rtl/trg_in_decoder.sv
// Trigger-line decoder: recovers triggers and check pulses, keeps a local count; stats under TRG_DEC_STATS_EN.
// Strobes registered 4 clocks after the releasing line edge; no backpressure, enb_in=0 abandons the pulse.
module trg_in_decoder
  import trg_dec_pkg::*;
#(
  parameter int TRG_MIN_WIDTH = 16,
  parameter int TRG_MAX_WIDTH = 24,
  parameter int CHK_MIN_WIDTH = 44,
  parameter int CHK_MAX_WIDTH = 56,
  parameter int GAP_MAX       = 16,
  parameter int STUCK_MAX     = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trg_in_N,
  input  logic        enb_in,
  input  logic        cnt_clr_in,
  output logic        trg_pulse_out,
  output logic [15:0] trg_cnt_out,
  output logic        chk_ok_out,
  output logic        chk_mismatch_out,
  output logic        chk_miss_out,
  output logic        width_err_out,
  output logic        stuck_out,
  output logic [15:0] glitch_cnt_out,
  output logic [15:0] width_err_cnt_out
);

  localparam logic [7:0] TRG_MIN  = 8'(TRG_MIN_WIDTH);
  localparam logic [7:0] TRG_MAX  = 8'(TRG_MAX_WIDTH);
  localparam logic [7:0] CHK_MIN  = 8'(CHK_MIN_WIDTH);
  localparam logic [7:0] CHK_MAX  = 8'(CHK_MAX_WIDTH);
  localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);
  localparam logic [7:0] STK_LIM  = 8'(STUCK_MAX);

  logic        line_hi, line_fall, line_rise;
  logic [2:0]  state, state_nxt;
  logic [7:0]  wcnt, gap;
  logic [1:0]  wcls;
  logic        chk_exp;
  logic        accept, ok, mism, miss, werr, glitch;
  logic [15:0] cnt_nxt;

  trg_line_sync u_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .line_in   (trg_in_N),
    .line_lvl  (line_hi),
    .line_fall (line_fall),
    .line_rise (line_rise)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ok        = 1'b0;
    mism      = 1'b0;
    miss      = 1'b0;
    werr      = 1'b0;
    glitch    = 1'b0;
    wcls      = width_class(wcnt, TRG_MIN, TRG_MAX, CHK_MIN, CHK_MAX);
    case (state)
      ST_IDLE: if (line_fall) state_nxt = ST_MEAS_TRG;
      ST_MEAS_TRG, ST_MEAS_CHK: begin
        if (line_rise) begin
          case (wcls)
            WC_GLITCH: begin
              // a glitch inside the check window leaves the gap count running
              glitch    = 1'b1;
              state_nxt = (state == ST_MEAS_CHK) ? ST_WAIT_CHK : ST_IDLE;
            end
            WC_TRG: begin
              accept    = 1'b1;
              miss      = (state == ST_MEAS_CHK) && chk_exp;
              state_nxt = ST_WAIT_CHK;
            end
            WC_CHK: begin
              if (state == ST_MEAS_CHK) begin
                ok   = chk_exp;
                mism = ~chk_exp;
              end else begin
                werr = 1'b1;
              end
              state_nxt = ST_IDLE;
            end
            default: begin
              werr      = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end else if (!line_hi && wcnt == STK_LIM) begin
          state_nxt = ST_STUCK;
        end
      end
      ST_WAIT_CHK: begin
        if (line_fall) begin
          state_nxt = ST_MEAS_CHK;
        end else if (line_hi && gap == GAP_LAST) begin
          miss      = chk_exp;
          state_nxt = ST_IDLE;
        end
      end
      ST_STUCK: if (line_hi) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!enb_in) begin
      state_nxt = ST_IDLE;
      accept    = 1'b0;
      ok        = 1'b0;
      mism      = 1'b0;
      miss      = 1'b0;
      werr      = 1'b0;
      glitch    = 1'b0;
    end
    cnt_nxt = cnt_clr_in ? 16'h0000 : (accept ? trg_cnt_out + 16'd1 : trg_cnt_out);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      wcnt             <= 8'd0;
      gap              <= 8'd0;
      chk_exp          <= 1'b0;
      trg_pulse_out    <= 1'b0;
      trg_cnt_out      <= 16'h0000;
      chk_ok_out       <= 1'b0;
      chk_mismatch_out <= 1'b0;
      chk_miss_out     <= 1'b0;
      width_err_out    <= 1'b0;
      stuck_out        <= 1'b0;
    end else begin
      if (line_fall)                     wcnt <= 8'd1;
      else if (!line_hi && wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
      if (accept)                                gap <= 8'd0;
      else if (state == ST_WAIT_CHK && line_hi)  gap <= gap + 8'd1;
      if (accept) chk_exp <= (cnt_nxt[CHK_PERIOD_BITS-1:0] == '0);
      state            <= state_nxt;
      trg_pulse_out    <= accept;
      trg_cnt_out      <= cnt_nxt;
      chk_ok_out       <= ok;
      chk_mismatch_out <= mism;
      chk_miss_out     <= miss;
      width_err_out    <= werr;
      if (enb_in) stuck_out <= (state_nxt == ST_STUCK);
    end
  end

`ifdef TRG_DEC_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in || cnt_clr_in) begin
      glitch_cnt_out    <= 16'h0000;
      width_err_cnt_out <= 16'h0000;
    end else begin
      if (glitch && glitch_cnt_out != 16'hFFFF)  glitch_cnt_out    <= glitch_cnt_out + 16'd1;
      if (werr && width_err_cnt_out != 16'hFFFF) width_err_cnt_out <= width_err_cnt_out + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats      = glitch;
  assign glitch_cnt_out    = 16'h0000;
  assign width_err_cnt_out = 16'h0000;
`endif

endmodule
